iomem_router: RTL and testbench

//  Shares the picosoc iomem master port among NUM_SLAVES peripherals (GPIO, PWM, timers, ...).

---
 rtl/iomem_router_pkg.sv | 19 +
 rtl/iomem_router.sv | 147 ++++++++++++++
 tb/tb_iomem_router.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_router_pkg.sv
// Shared constants for the iomem router: FSM state codes,
// default error read data, router base and error-counter helper.
package iomem_router_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  localparam logic [31:0] IOMEM_ERR_DATA = 32'hDEAD_BEEF;

  localparam logic [7:0] BASE_HI_ROUTER = 8'h03;

  function automatic logic [7:0] sat_inc8(
    input logic [7:0] v
  );
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/iomem_router.sv
// iomem_router: shares the picosoc iomem port among NUM_SLAVES slaves.
// Ports: clk/resetn (sync, active-low), m_* master side, s_* slave side,
// err_count/err_addr report unmapped and timed-out accesses.
module iomem_router
  import iomem_router_pkg::*;
#(
  parameter int          NUM_SLAVES = 4,
  parameter logic [7:0]  BASE_HI    = BASE_HI_ROUTER,
  parameter int          TIMEOUT    = 255,
  parameter logic [31:0] ERR_DATA   = IOMEM_ERR_DATA
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     m_valid,
  output logic                     m_ready,
  input  logic [3:0]               m_wstrb,
  input  logic [31:0]              m_addr,
  input  logic [31:0]              m_wdata,
  output logic [31:0]              m_rdata,
  output logic [NUM_SLAVES-1:0]    s_valid,
  input  logic [NUM_SLAVES-1:0]    s_ready,
  output logic [3:0]               s_wstrb,
  output logic [31:0]              s_addr,
  output logic [31:0]              s_wdata,
  input  logic [32*NUM_SLAVES-1:0] s_rdata,
  output logic [7:0]               err_count,
  output logic [31:0]              err_addr
);

  localparam int IW =
    (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    r_state;
  logic [IW-1:0] r_idx;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [3:0]    r_wstrb;
  logic [CW-1:0] r_cnt;
  logic          r_m_ready;
  logic [31:0]   r_m_rdata;
  logic [7:0]    r_err_count;
  logic [31:0]   r_err_addr;

  logic                  w_hit;
  logic                  w_map;
  logic                  w_ready;
  logic                  w_tmo;
  logic [NUM_SLAVES-1:0] w_sel;
  logic [31:0]           w_rd [NUM_SLAVES];
  logic [31:0]           w_rdata;

  assign w_hit = m_valid
    && (m_addr[31:24] == BASE_HI);
  assign w_map = (m_addr[23:20] == 4'd0)
    && (int'(m_addr[19:16]) < NUM_SLAVES);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLAVES; gi++) begin : g_sl
      assign w_sel[gi] = (r_idx == IW'(gi));
      assign w_rd[gi]  = w_sel[gi]
        ? s_rdata[32*gi +: 32] : 32'd0;
    end
  endgenerate

  always_comb begin
    w_rdata = 32'd0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      w_rdata = w_rdata | w_rd[i];
    end
  end

  assign w_ready = |(s_ready & w_sel);
  // Leaving in the TIMEOUT-th ACCESS cycle keeps
  // s_valid high for exactly TIMEOUT cycles.
  assign w_tmo = (r_cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_idx       <= '0;
      r_addr      <= 32'd0;
      r_wdata     <= 32'd0;
      r_wstrb     <= 4'd0;
      r_cnt       <= '0;
      r_m_ready   <= 1'b0;
      r_m_rdata   <= 32'd0;
      r_err_count <= 8'd0;
      r_err_addr  <= 32'd0;
    end else begin
      r_m_ready <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          // r_m_ready high: the request just served is
          // still on the bus and must not be re-taken.
          if (w_hit && !r_m_ready) begin
            r_idx   <= m_addr[16 +: IW];
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_wstrb <= m_wstrb;
            r_cnt   <= '0;
            if (w_map) begin
              r_state <= ST_ACCESS;
            end else begin
              r_state     <= ST_RESP;
              r_m_rdata   <= ERR_DATA;
              r_err_count <= sat_inc8(r_err_count);
              r_err_addr  <= m_addr;
            end
          end
        end
        ST_ACCESS: begin
          if (!m_valid) begin
            r_state <= ST_IDLE;
          end else if (w_ready) begin
            r_m_rdata <= w_rdata;
            r_state   <= ST_RESP;
          end else if (w_tmo) begin
            r_m_rdata   <= ERR_DATA;
            r_err_count <= sat_inc8(r_err_count);
            r_err_addr  <= r_addr;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        ST_RESP: begin
          r_m_ready <= 1'b1;
          r_state   <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_valid = (r_state == ST_ACCESS)
    ? w_sel : '0;
  assign m_ready   = r_m_ready;
  assign m_rdata   = r_m_rdata;
  assign s_addr    = r_addr;
  assign s_wdata   = r_wdata;
  assign s_wstrb   = r_wstrb;
  assign err_count = r_err_count;
  assign err_addr  = r_err_addr;

endmodule

// File: tb/tb_iomem_router.sv
// Testbench for iomem_router: transaction-level model predicts
// per-cycle s_valid/m_ready and response data/error state.
module tb_iomem_router;

  localparam int NS = 4;
  localparam int TO = 255;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  logic            clk = 1'b0;
  logic            resetn;
  logic            m_valid;
  logic            m_ready;
  logic [3:0]      m_wstrb;
  logic [31:0]     m_addr;
  logic [31:0]     m_wdata;
  logic [31:0]     m_rdata;
  logic [NS-1:0]   s_valid;
  logic [NS-1:0]   s_ready;
  logic [3:0]      s_wstrb;
  logic [31:0]     s_addr;
  logic [31:0]     s_wdata;
  logic [32*NS-1:0] s_rdata;
  logic [7:0]      err_count;
  logic [31:0]     err_addr;

  iomem_router #(
    .NUM_SLAVES(NS),
    .BASE_HI(8'h03),
    .TIMEOUT(TO),
    .ERR_DATA(ERR)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_wstrb(m_wstrb),
    .m_addr(m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_wstrb(s_wstrb),
    .s_addr(s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .err_count(err_count),
    .err_addr(err_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 1'b0;

  logic [NS-1:0] exp_sv [int];
  bit            exp_mr [int];
  logic [31:0]   exp_rdata;
  int            model_err = 0;
  logic [31:0]   model_eaddr = 32'd0;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_wstrb;

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the scheduled expectations.
  always @(negedge clk) begin
    logic [NS-1:0] esv;
    bit emr;
    if (chk_en) begin
      esv = exp_sv.exists(cyc) ? exp_sv[cyc] : '0;
      emr = exp_mr.exists(cyc);
      check("s_valid", 32'(s_valid), 32'(esv));
      check("m_ready", 32'(m_ready), 32'(emr));
      if (emr) begin
        check("m_rdata", m_rdata, exp_rdata);
        check("err_count", 32'(err_count),
              32'(model_err));
        check("err_addr", err_addr, model_eaddr);
      end
      if (esv != '0) begin
        check("s_addr", s_addr, cur_addr);
        check("s_wdata", s_wdata, cur_wdata);
        check("s_wstrb", 32'(s_wstrb), 32'(cur_wstrb));
      end
    end
  end

  // One CPU request; slave idx answers after w wait cycles.
  // lat = cycles from m_valid rise to m_ready (-1: none),
  // svc = cycles with any s_valid, rd = m_rdata at m_ready.
  task automatic do_txn(input logic [31:0] a,
                        input logic [3:0]  ws,
                        input logic [31:0] wd,
                        input int          w,
                        input logic [31:0] sd,
                        input int          hold,
                        output int          lat,
                        output int          svc,
                        output logic [31:0] rd);
    int c0, L, k, idx, n;
    bit hit, mapped, err;
    logic [NS-1:0] nz;
    @(posedge clk); #1;
    c0 = cyc;
    for (int j = 0; j < NS; j++)
      s_rdata[32*j +: 32] = $urandom;
    hit    = (a[31:24] == 8'h03);
    idx    = int'(a[19:16]);
    mapped = hit && (a[23:20] == 4'd0) && (idx < NS);
    if (mapped) s_rdata[32*idx +: 32] = sd;
    k = 0;
    L = -1;
    err = 1'b0;
    if (mapped) begin
      k = (w + 1 <= TO) ? w + 1 : TO;
      L = k + 2;
      err = (w + 1 > TO);
      for (int t = 1; t <= k; t++)
        exp_sv[c0 + t] = NS'(1) << idx;
    end else if (hit) begin
      L = 2;
      err = 1'b1;
    end
    if (hit) begin
      exp_mr[c0 + L] = 1'b1;
      exp_rdata = err ? ERR : s_rdata[32*idx +: 32];
    end
    if (err) begin
      model_err = (model_err < 255) ? model_err + 1 : 255;
      model_eaddr = a;
    end
    cur_addr  = a;
    cur_wdata = wd;
    cur_wstrb = ws;
    m_addr  = a;
    m_wdata = wd;
    m_wstrb = ws;
    m_valid = 1'b1;
    lat = -1;
    svc = 0;
    rd  = 32'd0;
    n = hit ? L + 6 : hold;
    for (int t = 0; t < n; t++) begin
      nz = NS'($urandom);
      if (mapped) nz[idx] = (t == 1 + w);
      s_ready = nz;
      if (s_valid != '0) svc++;
      if (m_ready) begin
        lat = t;
        rd  = m_rdata;
        break;
      end
      @(posedge clk); #1;
    end
    if (hit) check("latency_model", 32'(lat), 32'(L));
    @(posedge clk); #1;
    m_valid = 1'b0;
    s_ready = '0;
  endtask

  int lat, svc, c0;
  logic [31:0] rd, a;

  initial begin
    resetn  = 1'b0;
    m_valid = 1'b0;
    m_wstrb = 4'd0;
    m_addr  = 32'd0;
    m_wdata = 32'd0;
    s_ready = '0;
    s_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_m_ready", 32'(m_ready), 32'd0);
    check("rst_s_valid", 32'(s_valid), 32'd0);
    check("rst_err_count", 32'(err_count), 32'd0);
    check("rst_err_addr", err_addr, 32'd0);
    check("rst_m_rdata", m_rdata, 32'd0);
    resetn = 1'b1;

    // zero-wait write to slave 1
    do_txn(32'h0301_0000, 4'hF, 32'h1234_5678, 0,
           32'h0, 0, lat, svc, rd);
    check("t1_lat", 32'(lat), 32'd3);
    check("t1_svc", 32'(svc), 32'd1);

    // read slave 2 with 5 wait cycles
    do_txn(32'h0302_0004, 4'h0, 32'h0, 5,
           32'hCAFE_F00D, 0, lat, svc, rd);
    check("t2_lat", 32'(lat), 32'd8);
    check("t2_rd", rd, 32'hCAFE_F00D);
    check("t2_err", 32'(err_count), 32'd0);

    // unmapped index 7
    do_txn(32'h0307_0000, 4'h0, 32'h0, 0,
           32'h0, 0, lat, svc, rd);
    check("t3_lat", 32'(lat), 32'd2);
    check("t3_svc", 32'(svc), 32'd0);
    check("t3_rd", rd, 32'hDEAD_BEEF);
    check("t3_err", 32'(err_count), 32'd1);
    check("t3_eaddr", err_addr, 32'h0307_0000);

    // hung slave 0, then normal slave 3
    do_txn(32'h0300_0010, 4'h0, 32'h0, 1000,
           32'h1111_2222, 0, lat, svc, rd);
    check("t4_lat", 32'(lat), 32'd257);
    check("t4_svc", 32'(svc), 32'd255);
    check("t4_rd", rd, 32'hDEAD_BEEF);
    check("t4_err", 32'(err_count), 32'd2);
    do_txn(32'h0303_0020, 4'h0, 32'h0, 2,
           32'h1357_2468, 0, lat, svc, rd);
    check("t4b_lat", 32'(lat), 32'd5);
    check("t4b_rd", rd, 32'h1357_2468);

    // ready in the last allowed cycle beats timeout
    do_txn(32'h0300_0000, 4'h0, 32'h0, 254,
           32'h0BAD_CAFE, 0, lat, svc, rd);
    check("tie_lat", 32'(lat), 32'd257);
    check("tie_rd", rd, 32'h0BAD_CAFE);
    check("tie_err", 32'(err_count), 32'd2);
    do_txn(32'h0300_0000, 4'h0, 32'h0, 255,
           32'h0BAD_CAFE, 0, lat, svc, rd);
    check("late_rd", rd, 32'hDEAD_BEEF);
    check("late_err", 32'(err_count), 32'd3);

    // reset during ACCESS of slave 1
    @(posedge clk); #1;
    c0 = cyc;
    for (int j = 0; j < NS; j++)
      s_rdata[32*j +: 32] = $urandom;
    m_addr  = 32'h0301_0008;
    m_wdata = 32'h0;
    m_wstrb = 4'h0;
    cur_addr = m_addr;
    cur_wdata = m_wdata;
    cur_wstrb = m_wstrb;
    m_valid = 1'b1;
    for (int t = 1; t <= 3; t++) exp_sv[c0 + t] = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    check("t5_sv_before", 32'(s_valid), 32'h2);
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn  = 1'b1;
    m_valid = 1'b0;
    model_err = 0;
    model_eaddr = 32'd0;
    check("t5_sv_after", 32'(s_valid), 32'd0);
    check("t5_mready", 32'(m_ready), 32'd0);
    check("t5_err", 32'(err_count), 32'd0);
    check("t5_rdata", m_rdata, 32'd0);
    repeat (5) @(posedge clk);
    do_txn(32'h0301_0008, 4'h0, 32'h0, 1,
           32'hA5A5_1234, 0, lat, svc, rd);
    check("t5_lat", 32'(lat), 32'd4);
    check("t5_rd", rd, 32'hA5A5_1234);

    // foreign address held 20 cycles
    do_txn(32'h0400_0000, 4'h0, 32'h0, 0,
           32'h0, 20, lat, svc, rd);
    check("t6_lat", 32'(lat), 32'hFFFF_FFFF);
    check("t6_svc", 32'(svc), 32'd0);
    check("t6_err", 32'(err_count), 32'd0);

    // random mix
    for (int i = 0; i < 80; i++) begin
      int r, w;
      r = $urandom_range(0, 9);
      w = ($urandom_range(0, 19) == 0)
        ? $urandom_range(250, 258)
        : $urandom_range(0, 6);
      a = $urandom;
      a[1:0] = 2'b00;
      if (r < 7) begin
        a[31:16] = {8'h03, 4'h0, 4'($urandom_range(0, NS-1))};
      end else if (r < 9) begin
        a[31:24] = 8'h03;
        if (r == 7) a[23:20] = 4'($urandom_range(1, 15));
        else a[23:16] = 8'($urandom_range(NS, 15));
      end else begin
        a[31:24] = 8'h40 ^ 8'($urandom_range(0, 15));
      end
      do_txn(a, 4'($urandom), $urandom, w, $urandom,
             $urandom_range(1, 6), lat, svc, rd);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // saturate the error counter
    for (int i = 0; i < 260; i++) begin
      a = {8'h03, 4'($urandom_range(1, 15)), 20'h0};
      do_txn(a, 4'h0, 32'h0, 0, 32'h0, 0,
             lat, svc, rd);
    end
    check("sat_err", 32'(err_count), 32'hFF);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
